// File: rtl/trng_pkg.sv
// trng_pkg: shared constants, counter-width helper and VN state encoding
`default_nettype none

package trng_pkg;

  localparam int BYTE_W          = 8;
  localparam int SAMPLE_DIV_DEF  = 16;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int RCT_LIMIT_DEF   = 32;

  // Bits needed to hold values 0..max_val; SAMPLE_DIV counter uses max_val=SAMPLE_DIV-1
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  typedef enum logic [0:0] {
    VN_FIRST  = 1'b0,
    VN_SECOND = 1'b1
  } vn_state_t;

endpackage

`default_nettype wire

// File: rtl/trng_vn_debias.sv
// trng_vn_debias: von Neumann extractor over non-overlapping sample pairs
`default_nettype none

module trng_vn_debias
  import trng_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic sample_tick,
  input  logic s,
  output logic bit_valid,
  output logic bit_out
);

  vn_state_t state, state_nxt;
  logic      a, a_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= VN_FIRST;
      a     <= 1'b0;
    end else begin
      state <= state_nxt;
      a     <= a_nxt;
    end
  end

  // The emitted bit is the first sample of an unequal pair: (1,0)->1, (0,1)->0
  always_comb begin
    state_nxt = state;
    a_nxt     = a;
    bit_valid = 1'b0;
    bit_out   = a;
    if (clr) begin
      state_nxt = VN_FIRST;
      a_nxt     = 1'b0;
    end else if (sample_tick) begin
      case (state)
        VN_FIRST: begin
          a_nxt     = s;
          state_nxt = VN_SECOND;
        end
        VN_SECOND: begin
          bit_valid = (s != a);
          state_nxt = VN_FIRST;
        end
        default: state_nxt = VN_FIRST;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/trng_byte_collector.sv
// trng_byte_collector: synchronise, sample, debias, health-test and pack TRNG bits
`default_nettype none

module trng_byte_collector
  import trng_pkg::*;
#(
  parameter int SAMPLE_DIV  = SAMPLE_DIV_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int RCT_LIMIT   = RCT_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              rnd_in,
  output logic [BYTE_W-1:0] byte_data,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              health_fail,
  output logic              overflow
);

  localparam int DIV_W = cnt_w(SAMPLE_DIV - 1);
  localparam int RCT_W = cnt_w(RCT_LIMIT);
  localparam int BIT_W = $clog2(BYTE_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [RCT_W-1:0] RCT_MAX  = RCT_W'(RCT_LIMIT);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BYTE_W - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], rnd_in};
  end

  assign s = sync_q[SYNC_STAGES-1];

  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = en && (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           div_cnt <= '0;
    else if (!en || tick) div_cnt <= '0;
    else                  div_cnt <= div_cnt + DIV_W'(1);
  end

  logic bit_valid, bit_out;

  trng_vn_debias u_vn (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (!en),
    .sample_tick (tick),
    .s           (s),
    .bit_valid   (bit_valid),
    .bit_out     (bit_out)
  );

  logic [RCT_W-1:0] rct_cnt, rct_nxt;
  logic             prev_s;

  // A zero count marks "no previous sample" after enable, so the first tick loads 1
  always_comb begin
    rct_nxt = rct_cnt;
    if (rct_cnt == '0 || s != prev_s) rct_nxt = RCT_W'(1);
    else if (rct_cnt != RCT_MAX)      rct_nxt = rct_cnt + RCT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rct_cnt     <= '0;
      prev_s      <= 1'b0;
      health_fail <= 1'b0;
    end else if (!en) begin
      rct_cnt     <= '0;
      prev_s      <= 1'b0;
      health_fail <= 1'b0;
    end else if (tick) begin
      rct_cnt <= rct_nxt;
      prev_s  <= s;
      if (rct_nxt == RCT_MAX) health_fail <= 1'b1;
    end
  end

  logic [BIT_W-1:0]  bit_cnt;
  logic [BYTE_W-2:0] shift_q;
  logic              bit_take, byte_done, xfer, load;

  assign bit_take  = bit_valid && !health_fail;
  assign byte_done = bit_take && (bit_cnt == BIT_LAST);
  assign xfer      = byte_valid && byte_ready;
  assign load      = byte_done && (!byte_valid || byte_ready);

  // bit_cnt wraps 7->0 on its own, so completion and drop share one path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      shift_q <= '0;
    end else if (!en) begin
      bit_cnt <= '0;
      shift_q <= '0;
    end else if (bit_take) begin
      bit_cnt <= bit_cnt + BIT_W'(1);
      shift_q <= {shift_q[BYTE_W-3:0], bit_out};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_data  <= '0;
      byte_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (load) begin
        byte_data  <= {shift_q, bit_out};
        byte_valid <= 1'b1;
      end else if (xfer) begin
        byte_valid <= 1'b0;
      end
      if (byte_done && !load) overflow <= 1'b1;
    end
  end

endmodule

`default_nettype wire
